// File: rtl/gpu_pkg.sv
// Shared GPU types and sizes.
// Vector write bundle used by the writeback path.
package gpu_pkg;
  localparam int LANES  = 32;
  localparam int LW     = 16;
  localparam int VW     = LANES * LW;
  localparam int NREG   = 16;
  localparam int REG_AW = 4;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [VW-1:0]     data;
    logic [LANES-1:0]  mask;
  } vwr_t;
endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO for LSU load returns.
// Caller guarantees no push when full and no pop when empty.
module wb_fifo2
  import gpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  vwr_t       din_i,
  output vwr_t       head_o,
  output logic [1:0] count_o
);
  logic [1:0] cnt_q, cnt_d;
  logic       rd_q, wr_q;
  vwr_t       mem_q [2];

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i)
      cnt_d = cnt_q + 2'd1;
    else if (pop_i && !push_i)
      cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push_i) wr_q <= ~wr_q;
      if (pop_i)  rd_q <= ~rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU and buffered LSU results onto
// the register file's vector and scalar write ports.
module wb_arbiter #(
  parameter int LANES  = 32,
  parameter int LW     = 16,
  parameter int STARVE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aluValid,
  output logic                aluReady,
  input  logic                aluIsScalar,
  input  logic [3:0]          aluAddr,
  input  logic [LANES*LW-1:0] aluData,
  input  logic [LANES-1:0]    aluMask,
  input  logic [LW-1:0]       aluSData,
  input  logic                lsuValid,
  output logic                lsuReady,
  input  logic [3:0]          lsuAddr,
  input  logic [LANES*LW-1:0] lsuData,
  input  logic [LANES-1:0]    lsuMask,
  output logic                vEn,
  output logic [3:0]          vAddrW,
  output logic [LANES*LW-1:0] vDataW,
  output logic [LANES-1:0]    wMask,
  output logic                sEn,
  output logic [3:0]          sAddrW,
  output logic [LW-1:0]       sDataW
);
  localparam int SW = $clog2(STARVE + 1);

  gpu_pkg::vwr_t head, lsu_in, v_q, v_d;
  logic [1:0]    count;
  logic [SW-1:0] starve_q, starve_d;
  logic          head_vld, lsu_gnt, alu_vgnt, alu_sgnt, push;
  logic          vEn_q, vEn_d, sEn_q, sEn_d;
  logic [3:0]    sAddr_q, sAddr_d;
  logic [LW-1:0] sData_q, sData_d;

  assign lsu_in   = '{addr: lsuAddr, data: lsuData, mask: lsuMask};
  assign lsuReady = !rst && (count != 2'd2);
  assign push     = lsuValid && lsuReady;

  wb_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (lsu_gnt),
    .din_i   (lsu_in),
    .head_o  (head),
    .count_o (count)
  );

  // LSU takes the vector port when full, starved, or uncontested
  always_comb begin
    head_vld = count != 2'd0;
    lsu_gnt  = head_vld && (count == 2'd2
             || starve_q == SW'(STARVE)
             || !aluValid || aluIsScalar);
    alu_vgnt = aluValid && !aluIsScalar && !lsu_gnt;
    alu_sgnt = aluValid && aluIsScalar;
    aluReady = !rst && (aluIsScalar || alu_vgnt);
  end

  always_comb begin
    starve_d = starve_q;
    if (head_vld) begin
      if (lsu_gnt)
        starve_d = '0;
      else if (starve_q != SW'(STARVE))
        starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    v_d     = v_q;
    vEn_d   = 1'b0;
    sAddr_d = sAddr_q;
    sData_d = sData_q;
    sEn_d   = alu_sgnt;
    unique case (1'b1)
      lsu_gnt: begin
        vEn_d = 1'b1;
        v_d   = head;
      end
      alu_vgnt: begin
        vEn_d = 1'b1;
        v_d   = '{addr: aluAddr, data: aluData,
                  mask: aluMask};
      end
      default: ;
    endcase
    if (alu_sgnt) begin
      sAddr_d = aluAddr;
      sData_d = aluSData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      v_q      <= '0;
      vEn_q    <= 1'b0;
      sEn_q    <= 1'b0;
      sAddr_q  <= '0;
      sData_q  <= '0;
    end else begin
      starve_q <= starve_d;
      v_q      <= v_d;
      vEn_q    <= vEn_d;
      sEn_q    <= sEn_d;
      sAddr_q  <= sAddr_d;
      sData_q  <= sData_d;
    end
  end

  assign vEn    = vEn_q;
  assign vAddrW = v_q.addr;
  assign vDataW = v_q.data;
  assign wMask  = v_q.mask;
  assign sEn    = sEn_q;
  assign sAddrW = sAddr_q;
  assign sDataW = sData_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter.
module tb_wb_arbiter;
  import gpu_pkg::*;

  typedef struct packed {
    logic [3:0]    a;
    logic [LW-1:0] d;
  } sw_t;

  logic            clk, rst;
  logic            aluValid, aluReady, aluIsScalar;
  logic [3:0]      aluAddr, lsuAddr;
  logic [VW-1:0]   aluData, lsuData;
  logic [LANES-1:0] aluMask, lsuMask;
  logic [LW-1:0]   aluSData;
  logic            lsuValid, lsuReady;
  logic            vEn, sEn;
  logic [3:0]      vAddrW, sAddrW;
  logic [VW-1:0]   vDataW;
  logic [LANES-1:0] wMask;
  logic [LW-1:0]   sDataW;

  vwr_t vq[$];
  sw_t  sq[$];
  int   checks = 0;
  int   errors = 0;

  wb_arbiter #(.LANES(LANES), .LW(LW), .STARVE(3)) dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluReady(aluReady),
    .aluIsScalar(aluIsScalar), .aluAddr(aluAddr),
    .aluData(aluData), .aluMask(aluMask),
    .aluSData(aluSData),
    .lsuValid(lsuValid), .lsuReady(lsuReady),
    .lsuAddr(lsuAddr), .lsuData(lsuData),
    .lsuMask(lsuMask),
    .vEn(vEn), .vAddrW(vAddrW), .vDataW(vDataW),
    .wMask(wMask), .sEn(sEn), .sAddrW(sAddrW),
    .sDataW(sDataW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [VW-1:0] act,
                     logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rep(logic [LW-1:0] x);
    return {LANES{x}};
  endfunction

  function automatic vwr_t mk(logic [3:0] a,
                              logic [VW-1:0] d,
                              logic [LANES-1:0] m);
    vwr_t w;
    w.addr = a;
    w.data = d;
    w.mask = m;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    aluValid    = 1'b0;
    aluIsScalar = 1'b0;
    lsuValid    = 1'b0;
  endtask

  task automatic set_alu(bit v, bit s, logic [3:0] a,
                         logic [VW-1:0] d,
                         logic [LANES-1:0] m,
                         logic [LW-1:0] sd);
    aluValid    = v;
    aluIsScalar = s;
    aluAddr     = a;
    aluData     = d;
    aluMask     = m;
    aluSData    = sd;
  endtask

  task automatic set_lsu(bit v, logic [3:0] a,
                         logic [VW-1:0] d,
                         logic [LANES-1:0] m);
    lsuValid = v;
    lsuAddr  = a;
    lsuData  = d;
    lsuMask  = m;
  endtask

  // Monitor: every write pulse must match the next expected write
  always @(negedge clk) begin
    if (!rst && vEn) begin
      checks++;
      if (vq.size() == 0) begin
        errors++;
        $display("FAIL vwrite: unexpected addr %0h mask %0h",
                 vAddrW, wMask);
      end else begin
        vwr_t e;
        e = vq.pop_front();
        if (mk(vAddrW, vDataW, wMask) !== e) begin
          errors++;
          $display("FAIL vwrite: got a=%0h m=%0h d=%0h exp a=%0h m=%0h d=%0h",
                   vAddrW, wMask, vDataW,
                   e.addr, e.mask, e.data);
        end
      end
    end
    if (!rst && sEn) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL swrite: unexpected addr %0h", sAddrW);
      end else begin
        sw_t s;
        s = sq.pop_front();
        if ({sAddrW, sDataW} !== s) begin
          errors++;
          $display("FAIL swrite: got %0h/%0h exp %0h/%0h",
                   sAddrW, sDataW, s.a, s.d);
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    idle();
    set_alu(1, 1, 4'h1, '0, '0, 16'h1111);
    set_lsu(0, 4'h0, '0, '0);
    step();
    step();
    chk("rst_aluReady", aluReady, 0);
    chk("rst_lsuReady", lsuReady, 0);
    chk("rst_vEn", vEn, 0);
    chk("rst_sEn", sEn, 0);
    chk("rst_vAddrW", vAddrW, 0);
    chk("rst_vDataW", vDataW, 0);
    chk("rst_wMask", wMask, 0);
    chk("rst_sAddrW", sAddrW, 0);
    chk("rst_sDataW", sDataW, 0);
    idle();
    rst = 1'b0;
    step();

    // single vector ALU write
    set_alu(1, 0, 4'h5, rep(16'h1234), '1, '0);
    #2 chk("t1_aluReady", aluReady, 1);
    vq.push_back(mk(4'h5, rep(16'h1234), '1));
    step();
    idle();
    #2 chk("t1_vEn", vEn, 1);
    chk("t1_vAddrW", vAddrW, 4'h5);
    chk("t1_wMask", wMask, {LANES{1'b1}});
    step();
    #2 chk("t1_vEn_off", vEn, 0);
    step();

    // scalar ALU and LSU head granted together
    set_lsu(1, 4'h7, rep(16'h0707), 32'h00FF00FF);
    #2 chk("t2_lsuReady", lsuReady, 1);
    step();
    set_lsu(0, 4'h0, '0, '0);
    set_alu(1, 1, 4'h3, '0, '0, 16'hBEEF);
    #2 chk("t2_aluReady", aluReady, 1);
    vq.push_back(mk(4'h7, rep(16'h0707), 32'h00FF00FF));
    sq.push_back({4'h3, 16'hBEEF});
    step();
    idle();
    #2 chk("t2_sEn", sEn, 1);
    chk("t2_sAddrW", sAddrW, 4'h3);
    chk("t2_sDataW", sDataW, 16'hBEEF);
    chk("t2_vEn", vEn, 1);
    chk("t2_vAddrW", vAddrW, 4'h7);
    step();

    // starvation: LSU wins on 4th cycle as head
    k = 0;
    for (int c = 0; c < 6; c++) begin
      set_alu(1, 0, 4'(8 + k), rep(16'hA000 + 16'(k)),
              {LANES{1'b1}} ^ LANES'(k), '0);
      set_lsu(c == 0, 4'h6, rep(16'h6666), 32'hF0F0F0F0);
      #2 chk("t3_aluReady", aluReady, c != 4);
      if (c == 4) begin
        vq.push_back(mk(4'h6, rep(16'h6666), 32'hF0F0F0F0));
      end else begin
        vq.push_back(mk(4'(8 + k), rep(16'hA000 + 16'(k)),
                        {LANES{1'b1}} ^ LANES'(k)));
        k++;
      end
      step();
    end
    idle();
    step();

    // FIFO full takes priority over ALU
    set_alu(1, 0, 4'h1, rep(16'hB000), '1, '0);
    set_lsu(1, 4'h4, rep(16'hE000), 32'h12345678);
    #2 chk("t4_c0_aluReady", aluReady, 1);
    vq.push_back(mk(4'h1, rep(16'hB000), '1));
    step();
    set_alu(1, 0, 4'h2, rep(16'hB001), '1, '0);
    set_lsu(1, 4'h5, rep(16'hE001), 32'h9ABCDEF0);
    #2 chk("t4_c1_aluReady", aluReady, 1);
    chk("t4_c1_lsuReady", lsuReady, 1);
    vq.push_back(mk(4'h2, rep(16'hB001), '1));
    step();
    set_alu(1, 0, 4'h3, rep(16'hB002), '1, '0);
    set_lsu(0, 4'h0, '0, '0);
    #2 chk("t4_c2_aluReady", aluReady, 0);
    chk("t4_c2_lsuReady", lsuReady, 0);
    vq.push_back(mk(4'h4, rep(16'hE000), 32'h12345678));
    step();
    #2 chk("t4_c3_aluReady", aluReady, 1);
    chk("t4_c3_lsuReady", lsuReady, 1);
    vq.push_back(mk(4'h3, rep(16'hB002), '1));
    step();
    idle();
    vq.push_back(mk(4'h5, rep(16'hE001), 32'h9ABCDEF0));
    step();
    step();

    // ordering and masks, including a zero mask
    set_lsu(1, 4'h2, rep(16'hF000), 32'h0000FFFF);
    #2 chk("t5_c0_lsuReady", lsuReady, 1);
    step();
    set_lsu(1, 4'h2, rep(16'hF001), 32'hFFFF0000);
    #2 chk("t5_c1_lsuReady", lsuReady, 1);
    vq.push_back(mk(4'h2, rep(16'hF000), 32'h0000FFFF));
    step();
    set_lsu(0, 4'h0, '0, '0);
    set_alu(1, 0, 4'h9, rep(16'h5A5A), '0, '0);
    #2 chk("t5_c2_lsuReady", lsuReady, 1);
    chk("t5_c2_aluReady", aluReady, 1);
    vq.push_back(mk(4'h9, rep(16'h5A5A), '0));
    step();
    idle();
    vq.push_back(mk(4'h2, rep(16'hF001), 32'hFFFF0000));
    step();
    step();

    // reset mid-stream with a full FIFO
    set_alu(1, 0, 4'hC, rep(16'hC0C0), '1, '0);
    set_lsu(1, 4'hD, rep(16'hD0D0), '1);
    vq.push_back(mk(4'hC, rep(16'hC0C0), '1));
    step();
    set_alu(1, 0, 4'hE, rep(16'hE1E1), '1, '0);
    set_lsu(1, 4'hF, rep(16'hF1F1), '1);
    #2 chk("t6_c1_aluReady", aluReady, 1);
    chk("t6_c1_lsuReady", lsuReady, 1);
    step();
    set_lsu(0, 4'h0, '0, '0);
    set_alu(1, 1, 4'h1, '0, '0, 16'h7777);
    rst = 1'b1;
    #2 chk("t6_rst_lsuReady", lsuReady, 0);
    chk("t6_rst_aluReady", aluReady, 0);
    chk("t6_rst_vEn", vEn, 0);
    chk("t6_rst_vAddrW", vAddrW, 0);
    chk("t6_rst_wMask", wMask, 0);
    step();
    step();
    idle();
    rst = 1'b0;
    #2 chk("t6_post_lsuReady", lsuReady, 1);
    for (int i = 0; i < 6; i++) step();

    chk("vq_drained", vq.size(), 0);
    chk("sq_drained", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbitration stage sitting directly upstream of the vector/scalar register file: it collects results from the ALU and the load/store unit (LSU) and drives the register file's single vector write port and single scalar write port. ALU results are forwarded unbuffered. LSU returns pass through a 2-entry buffer. A starvation counter guarantees LSU forward progress. All write-port outputs are registered, giving exactly one cycle from handshake to write.

## Interface
Parameters:
- LANES, 32, SIMD lanes per vector register
- LW, 16, bits per lane
- STARVE, 3, max consecutive cycles a pending LSU head may lose arbitration

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- aluValid  in  1  ALU result valid
- aluReady  out  1  ALU result accepted this cycle (combinational)
- aluIsScalar  in  1  1 = scalar result (sData), 0 = vector result
- aluAddr  in  4  destination register
- aluData  in  LANES*LW  vector result, lane 0 in the MSBs
- aluMask  in  LANES  per-lane write enable
- aluSData  in  LW  scalar result
- lsuValid  in  1  LSU load return valid (vector only)
- lsuReady  out  1  LSU buffer not full
- lsuAddr  in  4  destination vector register
- lsuData  in  LANES*LW  load data
- lsuMask  in  LANES  per-lane write enable
- vEn  out  1  vector write enable to register file
- vAddrW  out  4  vector write address
- vDataW  out  LANES*LW  vector write data
- wMask  out  LANES  lane mask presented with vDataW
- sEn  out  1  scalar write enable
- sAddrW  out  4  scalar write address
- sDataW  out  LW  scalar write data

## Operation
- **LSU buffer:** 2-entry FIFO holding {addr, data, mask}.
  - A push occurs on lsuValid && lsuReady.
  - lsuReady = (count < 2), derived from registered count only. It is low when full, even if a pop happens that cycle.
- **Candidates each cycle:** ALU (aluValid) and LSU head (count > 0).
- **Scalar ALU result** (aluIsScalar = 1):
  - Always granted: aluReady = 1.
  - Uses only the scalar port, so the LSU head may be granted the vector port in the same cycle.
- **Vector arbitration** (one grant per cycle):
  - Grant LSU if count == 2, or if starve == STARVE, or if aluValid is 0 or aluIsScalar is 1.
  - Otherwise grant ALU.
  - aluReady = ALU granted.
- **Starve counter:**
  - Increments, saturating at STARVE, when the LSU head is pending and not granted.
  - Clears on an LSU grant.
  - Holds when count == 0.
- **Grant effects:**
  - Vector grant registers {vEn=1, vAddrW, vDataW, wMask}.
  - Scalar grant registers {sEn=1, sAddrW, sDataW}.
  - With no grant, vEn/sEn = 0 next cycle; address and data outputs hold their last value.
- **Ordering:** writes reach the register file in grant order. LSU returns stay in FIFO order.
- **Masks:** passed through unmodified. A grant with mask = 0 still issues vEn = 1; the register file leaves the contents unchanged.

## Timing
- **Reset:** vEn, sEn, vAddrW, vDataW, wMask, sAddrW, sDataW, count and starve are all 0.
  - Asserting rst mid-operation discards buffered LSU entries and any write registered but not yet seen.
  - aluReady = 0 and lsuReady = 0 while rst is high.
- **Latency:**
  - ALU handshake at edge N produces its write output during cycle N+1.
  - An LSU entry pushed at edge N is eligible at N+1, giving a minimum push-to-write latency of 2 cycles.
- **Throughput:**
  - Sustained rate is 1 vector write plus 1 scalar write per cycle.
  - With a continuous vector ALU stream, the LSU wins at least once every STARVE+1 cycles.
- **Simultaneous events:**
  - Push into an empty FIFO while the head is granted: not possible, because the head is not yet valid.
  - Push and pop in the same cycle at count == 1: count stays 1.

## Structure
- Shared package gpu_pkg holds:
  - LANES, LW, VW = LANES*LW, NREG = 16, REG_AW = 4.
  - A packed struct for a vector write {addr, data, mask}.
- Sub-module wb_fifo2 implements the 2-entry FIFO (push/pop/count). The arbiter, starve counter and output registers live in wb_arbiter.

## Test plan
- **Reset mid-stream:** fill the FIFO with 2 entries, assert rst → count = 0, lsuReady = 0 during reset, all outputs 0, and neither entry is ever written.
- **Single vector ALU write:** aluValid = 1, addr 5, mask 0xFFFFFFFF, data lanes = 0x1234 → aluReady = 1; next cycle vEn = 1, vAddrW = 5, wMask = 0xFFFFFFFF; the cycle after, vEn = 0.
- **Scalar + LSU same cycle:** scalar ALU write addr 3 = 0xBEEF, and LSU head addr 7 → both granted; next cycle sEn = 1, sAddrW = 3, vEn = 1, vAddrW = 7.
- **Starvation:** continuous vector ALU traffic plus one LSU entry → LSU granted on the 4th cycle after becoming head (STARVE = 3), and aluReady = 0 in that cycle.
- **FIFO full priority:** 2 LSU entries buffered and aluValid = 1 → LSU granted immediately; lsuReady = 0 until count drops to 1.
- **Ordering/mask:** LSU writes to addr 2 with masks 0x0000FFFF then 0xFFFF0000, and a zero-mask ALU write → three vEn pulses in grant order, with wMask values exactly as supplied, including 0.
